wb_stage_reg: RTL
=================

# wb_stage_reg

Parametrised MEM→WB pipeline register for the five-stage MIPS core. It captures MEM-stage results and RAM read data on each clock. It performs load byte/halfword lane extraction with optional sign extension, so the writeback value leaves the register already aligned. It also supports hold-on-stall (contents retained rather than zeroed), a separate flush that inserts a bubble, a per-entry valid bit, and an optional retired-instruction counter. It sits between the MEM stage and the register file write port, and feeds the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 8, power of two ≥ 16
- RADDR_W, 5, register-file address width
- PC_W, 32, debug PC width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall_in  in  1  hold all registered contents
- flush_in  in  1  replace next captured entry with a bubble
- valid_in  in  1  MEM-stage entry is a real instruction
- mem_rd_in  in  1  entry is a load; select aligned RAM data
- mem_sign_ext_in  in  1  sign-extend sub-word load
- mem_sel_in  in  DATA_W/8  byte-lane mask of the load
- ram_rdata_in  in  DATA_W  raw RAM read word, valid in the same cycle as the MEM inputs
- result_in  in  DATA_W  ALU/non-load result
- reg_we_in  in  1  register write enable
- reg_waddr_in  in  RADDR_W  destination register
- pc_in  in  PC_W  PC of the entry
- valid_out  out  1  registered valid
- wb_data_out  out  DATA_W  aligned writeback data
- reg_we_out  out  1  equals captured reg_we_in AND captured valid
- reg_waddr_out  out  RADDR_W  destination register
- pc_out  out  PC_W  debug PC
- misalign_out  out  1  captured load had an illegal lane mask
- retire_cnt_out  out  CNT_W  retired-instruction count

## Operation
- Capture priority per rising edge: reset > flush_in > stall_in > normal load.
- Flush:
  - valid_out, reg_we_out and misalign_out go to 0.
  - wb_data_out, reg_waddr_out and pc_out go to 0.
  - Flush wins over a simultaneous stall.
- Stall without flush: every output register holds its value; nothing is zeroed.
- Normal load: all fields are captured from the inputs.
  - reg_we_out = reg_we_in & valid_in.
  - valid_in=0 also forces misalign_out=0.
- wb_data selection, evaluated on the inputs before capture:
  - mem_rd_in=0 → result_in.
  - mem_rd_in=1 with legal mask → aligned value (see below).
  - mem_rd_in=1 with illegal mask → ram_rdata_in unmodified, and misalign_out=1 for that entry.
- Legal mask: a contiguous run of N set lanes, where N ∈ {1,2,4,…,DATA_W/8}, starting at lane index L with L mod N = 0.
- Aligned value:
  - Take ram_rdata_in >> (8·L) and keep its low 8·N bits.
  - Upper bits are filled with bit 8·N−1 of that field if mem_sign_ext_in=1, otherwise 0.
  - Full-width mask: no extension.
- Lane 0 is bits [7:0] (little-endian lane numbering).
- Retire counter:
  - Increments by 1 on each edge that performs a normal load with valid_in=1.
  - Saturates at 2^CNT_W−1; no wrap.
  - Stalled or flushed edges do not count.

## Timing
- Latency 1 cycle: inputs presented before edge k appear on the outputs after edge k.
- Every output is registered, with no combinational path from inputs to outputs.
- Reset values: valid_out=0, wb_data_out=0, reg_we_out=0, reg_waddr_out=0, pc_out=0, misalign_out=0, retire_cnt_out=0.
- Reset asserted mid-stall or mid-flush clears everything immediately; on the first edge after deassertion, normal priority applies.
- stall_in held for multiple cycles: outputs remain stable for the entire duration; the first edge with stall_in=0 captures the current inputs.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - Counter register and saturation logic are built.
  - retire_cnt_out behaves as in Operation.
- WB_RETIRE_CNT_EN undefined:
  - No counter flops.
  - retire_cnt_out is tied to 0.
  - All other behaviour is identical.

## Test plan
- Byte load, sign-extended: DATA_W=32, mem_rd_in=1, mem_sel_in=4'b0100, ram_rdata_in=0x12F45678, mem_sign_ext_in=1 → wb_data_out=0xFFFFFFF4 after one edge. Same stimulus with mem_sign_ext_in=0 → 0x000000F4.
- Halfword load and illegal mask:
  - mem_sel_in=4'b1100, ram_rdata_in=0x8001ABCD, sign-extended → 0xFFFF8001.
  - mem_sel_in=4'b0110 → wb_data_out=0x8001ABCD, misalign_out=1.
- Stall hold: capture result_in=0x0000002A, reg_waddr_in=5'd9, valid_in=1. Assert stall_in for 3 cycles while inputs change → outputs stay 0x2A/9/valid for all three cycles. After release, the next edge captures the new inputs.
- Flush beats stall: stall_in=1 and flush_in=1 together → valid_out=0, reg_we_out=0, wb_data_out=0 after the edge; retire_cnt_out unchanged.
- Retire counter: CNT_W=4 with the macro on, 20 consecutive valid un-stalled edges → retire_cnt_out=15. With the macro off → retire_cnt_out=0 throughout.
- Asynchronous reset: assert reset between edges while valid_out=1 → all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/wb_stage_reg_if.sv
// Bundle of MEM-stage inputs and WB-stage outputs for wb_stage_reg.
// The slave modport is the pipeline register; the master modport is its environment.
interface wb_stage_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 32
);
  logic                 stall_in;
  logic                 flush_in;
  logic                 valid_in;
  logic                 mem_rd_in;
  logic                 mem_sign_ext_in;
  logic [DATA_W/8-1:0]  mem_sel_in;
  logic [DATA_W-1:0]    ram_rdata_in;
  logic [DATA_W-1:0]    result_in;
  logic                 reg_we_in;
  logic [RADDR_W-1:0]   reg_waddr_in;
  logic [PC_W-1:0]      pc_in;

  logic                 valid_out;
  logic [DATA_W-1:0]    wb_data_out;
  logic                 reg_we_out;
  logic [RADDR_W-1:0]   reg_waddr_out;
  logic [PC_W-1:0]      pc_out;
  logic                 misalign_out;
  logic [CNT_W-1:0]     retire_cnt_out;

  modport slave (
    input  stall_in, flush_in, valid_in, mem_rd_in, mem_sign_ext_in, mem_sel_in,
           ram_rdata_in, result_in, reg_we_in, reg_waddr_in, pc_in,
    output valid_out, wb_data_out, reg_we_out, reg_waddr_out, pc_out, misalign_out,
           retire_cnt_out
  );

  modport master (
    output stall_in, flush_in, valid_in, mem_rd_in, mem_sign_ext_in, mem_sel_in,
           ram_rdata_in, result_in, reg_we_in, reg_waddr_in, pc_in,
    input  valid_out, wb_data_out, reg_we_out, reg_waddr_out, pc_out, misalign_out,
           retire_cnt_out
  );
endinterface

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register with load lane extraction, stall hold, flush bubble and
// an optional saturating retire counter (built when WB_RETIRE_CNT_EN is defined).
module wb_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 32
) (
  input logic            clk,
  input logic            reset,
  wb_stage_reg_if.slave  bus
);

  localparam int unsigned Lanes  = DATA_W / 8;
  localparam int unsigned NSizes = $clog2(Lanes) + 1;

  logic               legal;
  int unsigned        lane_n;
  int unsigned        lane_l;
  logic [Lanes-1:0]   cand;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  keep_mask;
  logic [DATA_W-1:0]  sign_mask;
  logic [DATA_W-1:0]  aligned;
  logic [DATA_W-1:0]  wb_data_sel;

  // Search every naturally aligned power-of-two lane run for an exact mask match.
  always_comb begin
    legal  = 1'b0;
    lane_n = Lanes;
    lane_l = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NSizes; k++) begin
      for (int unsigned l = 0; l < Lanes; l++) begin
        if ((l % (32'd1 << k)) == 0) begin
          cand = ({Lanes{1'b1}} >> (Lanes - (32'd1 << k))) << l;
          if (bus.mem_sel_in == cand) begin
            legal  = 1'b1;
            lane_n = 32'd1 << k;
            lane_l = l;
          end
        end
      end
    end
  end

  always_comb begin
    shifted   = bus.ram_rdata_in >> (8 * lane_l);
    keep_mask = {DATA_W{1'b1}} >> (DATA_W - 8 * lane_n);
    sign_mask = keep_mask & ~(keep_mask >> 1);
    aligned   = shifted & keep_mask;
    // Full-width loads have an empty ~keep_mask, so extension is a no-op there.
    if (bus.mem_sign_ext_in && |(shifted & sign_mask)) begin
      aligned = aligned | ~keep_mask;
    end
    if (!bus.mem_rd_in) begin
      wb_data_sel = bus.result_in;
    end else if (legal) begin
      wb_data_sel = aligned;
    end else begin
      wb_data_sel = bus.ram_rdata_in;
    end
  end

  logic               valid_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               reg_we_q;
  logic [RADDR_W-1:0] reg_waddr_q;
  logic [PC_W-1:0]    pc_q;
  logic               misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      pc_q        <= '0;
      misalign_q  <= 1'b0;
    end else if (bus.flush_in) begin
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      pc_q        <= '0;
      misalign_q  <= 1'b0;
    end else if (!bus.stall_in) begin
      valid_q     <= bus.valid_in;
      wb_data_q   <= wb_data_sel;
      reg_we_q    <= bus.reg_we_in & bus.valid_in;
      reg_waddr_q <= bus.reg_waddr_in;
      pc_q        <= bus.pc_in;
      misalign_q  <= bus.valid_in & bus.mem_rd_in & ~legal;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (!bus.flush_in && !bus.stall_in && bus.valid_in && (retire_cnt_q != '1)) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign bus.retire_cnt_out = retire_cnt_q;
`else
  assign bus.retire_cnt_out = '0;
`endif

  assign bus.valid_out     = valid_q;
  assign bus.wb_data_out   = wb_data_q;
  assign bus.reg_we_out    = reg_we_q;
  assign bus.reg_waddr_out = reg_waddr_q;
  assign bus.pc_out        = pc_q;
  assign bus.misalign_out  = misalign_q;

endmodule
